// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: transmit-arbiter state encoding and the
// filler byte placed on the wire when a stalled frame is cut short.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ABORT  = 2'd2,
        DRAIN  = 2'd3
    } tx_arb_state_t;

    localparam logic [7:0] ETH_ABORT_BYTE = 8'h00;

endpackage

// File: rtl/rr_arb_sel.sv
// Combinational round-robin picker: returns the first asserted request
// found searching upward from (last + 1) mod S_COUNT, wrapping around.
module rr_arb_sel #(
    parameter int S_COUNT    = 4,
    parameter int CL_S_COUNT = $clog2(S_COUNT)
) (
    input  logic [S_COUNT-1:0]    request,
    input  logic [CL_S_COUNT-1:0] last,
    output logic [CL_S_COUNT-1:0] index,
    output logic                  found
);

    int                  pos;
    logic [CL_S_COUNT-1:0] pos_idx;

    // Scan all ports starting just after the previous winner; the first hit wins.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        found   = 1'b0;
        index   = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 1; k <= S_COUNT; k++) begin
            pos     = (int'(last) + k) % S_COUNT;
            pos_idx = CL_S_COUNT'(pos);
            if (!found && request[pos_idx]) begin
                found = 1'b1;
                index = pos_idx;
            end
        end
    end

endmodule

// File: rtl/eth_mac_tx_arb.sv
// Frame-granular round-robin arbiter feeding one MAC transmit stream from
// S_COUNT byte-wide sources. A grant is held until the source's tlast beat
// is accepted; a stall watchdog terminates a starved frame as errored and
// then drains the remainder of that frame from its source.
// Optional statistics counters are built when ETH_MAC_TX_ARB_STATS_EN is defined.
module eth_mac_tx_arb
    import eth_pkg::*;
#(
    parameter int S_COUNT    = 4,
    parameter int TIMEOUT    = 64,
    parameter int CL_S_COUNT = $clog2(S_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [S_COUNT*8-1:0]    s_axis_tdata,
    input  logic [S_COUNT-1:0]      s_axis_tvalid,
    output logic [S_COUNT-1:0]      s_axis_tready,
    input  logic [S_COUNT-1:0]      s_axis_tlast,
    input  logic [S_COUNT-1:0]      s_axis_tuser,
    output logic [7:0]              m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    input  logic                    cfg_enable,
    output logic                    grant_valid,
    output logic [CL_S_COUNT-1:0]   grant_index,
    output logic                    abort_event
`ifdef ETH_MAC_TX_ARB_STATS_EN
    ,
    output logic [S_COUNT*16-1:0]   stat_frame_count,
    output logic [15:0]             stat_abort_count
`endif
);

    // Counter must hold TIMEOUT-1; keep one bit when the watchdog is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] STALL_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] STALL_MAX  = '1;

    tx_arb_state_t         state;
    logic [CL_S_COUNT-1:0] last_ptr;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CL_S_COUNT-1:0] pick_index;
    logic                  pick_found;
    logic                  cur_valid;
    logic                  cur_last;
    logic                  frame_done;

    rr_arb_sel #(
        .S_COUNT    (S_COUNT),
        .CL_S_COUNT (CL_S_COUNT)
    ) u_sel (
        .request (s_axis_tvalid),
        .last    (last_ptr),
        .index   (pick_index),
        .found   (pick_found)
    );

    assign cur_valid  = s_axis_tvalid[grant_index];
    assign cur_last   = s_axis_tlast[grant_index];
    assign frame_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Datapath steering: pass the granted port through, emit the abort beat, or sink the drain.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        case (state)
            ACTIVE: begin
                m_axis_tdata               = s_axis_tdata[int'(grant_index) * 8 +: 8];
                m_axis_tvalid              = cur_valid;
                m_axis_tlast               = cur_last;
                m_axis_tuser               = s_axis_tuser[grant_index];
                s_axis_tready[grant_index] = m_axis_tready;
            end
            ABORT: begin
                m_axis_tdata  = ETH_ABORT_BYTE;
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
            end
            DRAIN: begin
                s_axis_tready[grant_index] = 1'b1;
            end
            default: ;
        endcase
    end

    // Grant FSM with stall watchdog; all status outputs are registered here.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_index <= '0;
            last_ptr    <= CL_S_COUNT'(S_COUNT - 1);
            abort_event <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            abort_event <= 1'b0;
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (cfg_enable && pick_found) begin
                        grant_index <= pick_index;
                        last_ptr    <= pick_index;
                        grant_valid <= 1'b1;
                        state       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (frame_done) begin
                        grant_valid <= 1'b0;
                        stall_cnt   <= '0;
                        state       <= IDLE;
                    end else if (TIMEOUT != 0 && !cur_valid) begin
                        if (stall_cnt == STALL_LAST) begin
                            abort_event <= 1'b1;
                            stall_cnt   <= '0;
                            state       <= ABORT;
                        end else if (stall_cnt != STALL_MAX) begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end else begin
                        stall_cnt <= '0;
                    end
                end
                ABORT: begin
                    if (m_axis_tready) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cur_valid && cur_last) begin
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ETH_MAC_TX_ARB_STATS_EN
    logic [15:0] frame_cnt [S_COUNT];
    logic [15:0] abort_cnt;

    // Per-port delivered-frame counters and an abort counter, all wrapping.
    always_ff @(posedge clk) begin
        // NOTE: these are a handful of flops read directly as status, not a RAM,
        // so each entry is cleared by reset.
        if (rst) begin
            for (int i = 0; i < S_COUNT; i++) begin
                frame_cnt[i] <= '0;
            end
            abort_cnt <= '0;
        end else begin
            if (state == ACTIVE && frame_done) begin
                frame_cnt[grant_index] <= frame_cnt[grant_index] + 16'd1;
            end
            if (abort_event) begin
                abort_cnt <= abort_cnt + 16'd1;
            end
        end
    end

    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_stat
        assign stat_frame_count[gi*16 +: 16] = frame_cnt[gi];
    end
    assign stat_abort_count = abort_cnt;
`endif

endmodule

// File: tb/tb_eth_mac_tx_arb.sv
// Directed bench for eth_mac_tx_arb (S_COUNT=4, TIMEOUT=64). Sources are
// bench-side frame generators whose bytes encode {port, byte index}; the
// MAC side is captured beat by beat and compared with hand-derived values.
module tb_eth_mac_tx_arb;

    localparam int S_COUNT = 4;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         cyc;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [S_COUNT*8-1:0] s_axis_tdata;
    logic [S_COUNT-1:0]   s_axis_tvalid;
    logic [S_COUNT-1:0]   s_axis_tready;
    logic [S_COUNT-1:0]   s_axis_tlast;
    logic [S_COUNT-1:0]   s_axis_tuser;
    logic [7:0]           m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic                 m_axis_tuser;
    logic                 cfg_enable;
    logic                 grant_valid;
    logic [1:0]           grant_index;
    logic                 abort_event;
`ifdef ETH_MAC_TX_ARB_STATS_EN
    logic [S_COUNT*16-1:0] stat_frame_count;
    logic [15:0]           stat_abort_count;
`endif

    eth_mac_tx_arb #(
        .S_COUNT (S_COUNT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .cfg_enable    (cfg_enable),
        .grant_valid   (grant_valid),
        .grant_index   (grant_index),
        .abort_event   (abort_event)
`ifdef ETH_MAC_TX_ARB_STATS_EN
        ,
        .stat_frame_count (stat_frame_count),
        .stat_abort_count (stat_abort_count)
`endif
    );

    always #5 clk = ~clk;

    int    passed = 0;
    int    failed = 0;
    int    total  = 0;
    int    cyc    = 0;

    int    frames_left [S_COUNT];
    int    flen        [S_COUNT];
    int    fidx        [S_COUNT];
    bit    hold        [S_COUNT];

    beat_t beats [$];
    int    grant_q [$];
    int    abort_seen = 0;
    int    abort_cyc  = -1;
    logic  prev_gv    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < S_COUNT; i++) begin
            s_axis_tvalid[i]       = (frames_left[i] > 0) && !hold[i];
            s_axis_tdata[i*8 +: 8] = 8'(i * 64 + fidx[i]);
            s_axis_tlast[i]        = (fidx[i] == flen[i] - 1);
            s_axis_tuser[i]        = 1'b0;
        end
    endtask

    task automatic load(input int port, input int nframes, input int len);
        frames_left[port] = nframes;
        flen[port]        = len;
        fidx[port]        = 0;
        hold[port]        = 1'b0;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < S_COUNT; i++) begin
            load(i, 0, 1);
        end
    endtask

    // One clock: sample everything at the falling edge, then advance sources just after the rise.
    task automatic tick();
        bit hs [S_COUNT];
        @(negedge clk);
        for (int i = 0; i < S_COUNT; i++) begin
            hs[i] = s_axis_tvalid[i] && s_axis_tready[i];
        end
        if (m_axis_tvalid && m_axis_tready) begin
            beats.push_back('{m_axis_tdata, m_axis_tlast, m_axis_tuser, cyc});
        end
        if (abort_event) begin
            abort_seen++;
            abort_cyc = cyc;
        end
        if (grant_valid && !prev_gv) begin
            grant_q.push_back(int'(grant_index));
        end
        prev_gv = grant_valid;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < S_COUNT; i++) begin
            if (hs[i]) begin
                if (fidx[i] == flen[i] - 1) begin
                    fidx[i] = 0;
                    frames_left[i]--;
                end else begin
                    fidx[i]++;
                end
            end
        end
        drive();
    endtask

    initial begin
        int err;
        int nlast;
        int load_cyc;
        int hold_cyc;
        int en_cyc;
        int base;

        // ---------------- Reset state ----------------
        rst           = 1'b1;
        cfg_enable    = 1'b1;
        m_axis_tready = 1'b1;
        clear_sources();
        drive();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_index", 32'(grant_index), 32'd0);
        check("rst_abort_event", 32'(abort_event), 32'd0);
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_m_tuser", 32'(m_axis_tuser), 32'd0);
        check("rst_m_tdata", 32'(m_axis_tdata), 32'd0);

        // ---------------- Ports 0 and 2, one 64-byte frame each ----------------
        beats.delete();
        grant_q.delete();
        load(0, 1, 64);
        load(2, 1, 64);
        drive();
        load_cyc = cyc;
        for (int n = 0; n < 400 && (frames_left[0] + frames_left[2]) > 0; n++) tick();
        tick();
        check("t1_done", 32'(frames_left[0] + frames_left[2]), 32'd0);
        check("t1_beats", 32'(beats.size()), 32'd128);
        check("t1_grant_count", 32'(grant_q.size()), 32'd2);
        if (grant_q.size() == 2) begin
            check("t1_grant0", 32'(grant_q[0]), 32'd0);
            check("t1_grant1", 32'(grant_q[1]), 32'd2);
        end
        if (beats.size() == 128) begin
            err = 0;
            for (int j = 0; j < 128; j++) begin
                if (beats[j].data !== 8'((j / 64) * 128 + (j % 64))) err++;
                if (beats[j].last !== ((j % 64) == 63)) err++;
                if (beats[j].user !== 1'b0) err++;
            end
            check("t1_data_errors", 32'(err), 32'd0);
            check("t1_first_beat_cyc", 32'(beats[0].cyc), 32'(load_cyc + 1));
            check("t1_bubble_gap", 32'(beats[64].cyc - beats[63].cyc), 32'd2);
        end
        check("t1_grant_index_held", 32'(grant_index), 32'd2);
        check("t1_idle_grant_valid", 32'(grant_valid), 32'd0);

        // ---------------- All ports continuously valid, 8 frames of 10 bytes ----------------
        rst = 1'b1;
        clear_sources();
        drive();
        tick();
        rst = 1'b0;
        beats.delete();
        grant_q.delete();
        for (int i = 0; i < S_COUNT; i++) load(i, 2, 10);
        drive();
        for (int n = 0; n < 300 && (frames_left[0] + frames_left[1] + frames_left[2] + frames_left[3]) > 0; n++) tick();
        tick();
        check("t2_beats", 32'(beats.size()), 32'd80);
        check("t2_grant_count", 32'(grant_q.size()), 32'd8);
        if (grant_q.size() == 8) begin
            for (int f = 0; f < 8; f++) begin
                check($sformatf("t2_grant%0d", f), 32'(grant_q[f]), 32'(f % 4));
            end
        end
        if (beats.size() == 80) begin
            err   = 0;
            nlast = 0;
            for (int j = 0; j < 80; j++) begin
                if (beats[j].data !== 8'(((j / 10) % 4) * 64 + (j % 10))) err++;
                if (beats[j].last) nlast++;
            end
            check("t2_no_interleave", 32'(err), 32'd0);
            check("t2_tlast_count", 32'(nlast), 32'd8);
        end

        // ---------------- Watchdog abort on port 1 ----------------
        beats.delete();
        grant_q.delete();
        load(1, 1, 20);
        drive();
        for (int n = 0; n < 50 && beats.size() < 5; n++) tick();
        check("t3_five_beats", 32'(beats.size()), 32'd5);
        hold[1] = 1'b1;
        drive();
        hold_cyc = cyc;
        for (int n = 0; n < 200 && abort_seen == 0; n++) tick();
        check("t3_abort_seen", 32'(abort_seen), 32'd1);
        check("t3_abort_cyc", 32'(abort_cyc), 32'(hold_cyc + TIMEOUT));
        check("t3_drain_tready", 32'(s_axis_tready), 32'b0010);
        check("t3_drain_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t3_beats_with_abort", 32'(beats.size()), 32'd6);
        if (beats.size() == 6) begin
            check("t3_beat4_data", 32'(beats[4].data), 32'h44);
            check("t3_beat4_last", 32'(beats[4].last), 32'd0);
            check("t3_abort_data", 32'(beats[5].data), 32'h00);
            check("t3_abort_last", 32'(beats[5].last), 32'd1);
            check("t3_abort_user", 32'(beats[5].user), 32'd1);
        end
        for (int n = 0; n < 5; n++) tick();
        hold[1] = 1'b0;
        drive();
        for (int n = 0; n < 100 && frames_left[1] > 0; n++) tick();
        tick();
        check("t3_drained", 32'(frames_left[1]), 32'd0);
        check("t3_no_leak", 32'(beats.size()), 32'd6);
        check("t3_single_pulse", 32'(abort_seen), 32'd1);
        check("t3_end_grant_valid", 32'(grant_valid), 32'd0);

        // ---------------- Long back-pressure mid-frame, port 2 ----------------
        beats.delete();
        grant_q.delete();
        load(2, 1, 30);
        drive();
        for (int n = 0; n < 50 && beats.size() < 10; n++) tick();
        m_axis_tready = 1'b0;
        for (int n = 0; n < 200; n++) tick();
        check("t4_no_abort", 32'(abort_seen), 32'd1);
        check("t4_still_granted", 32'(grant_valid), 32'd1);
        check("t4_stalled_beats", 32'(beats.size()), 32'd10);
        check("t4_tready_low", 32'(s_axis_tready), 32'd0);
        m_axis_tready = 1'b1;
        for (int n = 0; n < 100 && frames_left[2] > 0; n++) tick();
        tick();
        check("t4_beats", 32'(beats.size()), 32'd30);
        if (beats.size() == 30) begin
            err = 0;
            for (int j = 0; j < 30; j++) begin
                if (beats[j].data !== 8'(128 + j)) err++;
                if (beats[j].last !== (j == 29)) err++;
            end
            check("t4_data_errors", 32'(err), 32'd0);
        end

        // ---------------- cfg_enable dropped mid-frame on port 3 ----------------
        beats.delete();
        grant_q.delete();
        load(3, 1, 20);
        drive();
        for (int n = 0; n < 50 && beats.size() < 5; n++) tick();
        cfg_enable = 1'b0;
        load(0, 1, 10);
        drive();
        for (int n = 0; n < 100 && frames_left[3] > 0; n++) tick();
        for (int n = 0; n < 10; n++) tick();
        check("t5_port3_done", 32'(frames_left[3]), 32'd0);
        check("t5_beats_disabled", 32'(beats.size()), 32'd20);
        check("t5_no_grant_disabled", 32'(grant_valid), 32'd0);
        check("t5_port0_waiting", 32'(frames_left[0]), 32'd1);
        cfg_enable = 1'b1;
        en_cyc = cyc;
        for (int n = 0; n < 50 && frames_left[0] > 0; n++) tick();
        tick();
        check("t5_beats_total", 32'(beats.size()), 32'd30);
        if (beats.size() == 30) begin
            check("t5_regrant_cyc", 32'(beats[20].cyc), 32'(en_cyc + 1));
            check("t5_regrant_data", 32'(beats[20].data), 32'h00);
        end
        check("t5_grant_count", 32'(grant_q.size()), 32'd2);
        if (grant_q.size() == 2) begin
            check("t5_grant_port0", 32'(grant_q[1]), 32'd0);
        end

        // ---------------- Reset mid-frame ----------------
`ifdef ETH_MAC_TX_ARB_STATS_EN
        check("t6_stat_abort_pre", 32'(stat_abort_count), 32'd1);
`endif
        beats.delete();
        load(1, 1, 20);
        load(2, 1, 20);
        drive();
        for (int n = 0; n < 50 && beats.size() < 5; n++) tick();
        check("t6_midframe", 32'(grant_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_sources();
        load(0, 1, 4);
        load(2, 1, 4);
        drive();
        #1;
        check("t6_rst_grant_valid", 32'(grant_valid), 32'd0);
        check("t6_rst_tready", 32'(s_axis_tready), 32'd0);
        check("t6_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t6_rst_grant_index", 32'(grant_index), 32'd0);
`ifdef ETH_MAC_TX_ARB_STATS_EN
        check("t6_stat_frames_zero", 32'(stat_frame_count != '0), 32'd0);
        check("t6_stat_abort_zero", 32'(stat_abort_count), 32'd0);
`endif
        tick();
        check("t6_post_grant_valid", 32'(grant_valid), 32'd1);
        check("t6_post_grant_index", 32'(grant_index), 32'd0);
        beats.delete();
        for (int n = 0; n < 50 && (frames_left[0] + frames_left[2]) > 0; n++) tick();
        tick();
        check("t6_post_beats", 32'(beats.size()), 32'd8);
        if (beats.size() == 8) begin
            base = 0;
            err  = 0;
            for (int j = 0; j < 8; j++) begin
                if (beats[j].data !== 8'((j / 4) * 128 + (j % 4))) err++;
            end
            check("t6_post_data_errors", 32'(err + base), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/eth_mac_tx_arb.md
Name: eth_mac_tx_arb

Overview:
- Frame-granular round-robin arbiter that shares one MAC transmit AXI-stream input between S_COUNT byte-wide frame sources.
- Sits directly upstream of the 10/100/1000 MAC TX path in the tx_clk domain.
- Never interleaves frames: a grant holds until the granted source's tlast beat is accepted.
- Includes a stall watchdog. If a granted source stops supplying data mid-frame, the arbiter terminates the MAC frame as errored, so the MAC never underflows indefinitely.

Parameters:
- S_COUNT, 4, number of source ports (2..16).
- TIMEOUT, 64, idle cycles (granted source tvalid low, mid-frame) before abort; 0 disables the watchdog.
- CL_S_COUNT, $clog2(S_COUNT), width of the grant index (derived, do not override).

Ports:
- clk  in  1  tx clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  S_COUNT*8  per-source data; port i occupies bits [8i+7:8i].
- s_axis_tvalid  in  S_COUNT  per-source valid.
- s_axis_tready  out  S_COUNT  per-source ready.
- s_axis_tlast  in  S_COUNT  per-source end of frame.
- s_axis_tuser  in  S_COUNT  per-source bad-frame flag.
- m_axis_tdata  out  8  to MAC tx_axis_tdata.
- m_axis_tvalid  out  1  to MAC.
- m_axis_tready  in  1  from MAC.
- m_axis_tlast  out  1  to MAC.
- m_axis_tuser  out  1  to MAC; 1 marks the frame bad.
- cfg_enable  in  1  0 blocks new grants; an in-progress frame still completes.
- grant_valid  out  1  a frame is in progress.
- grant_index  out  CL_S_COUNT  currently or last granted port.
- abort_event  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset values:
  - state=IDLE, grant_valid=0, grant_index=0.
  - last grant pointer = S_COUNT-1, so port 0 wins first.
  - abort_event=0, stall counter=0.
  - All s_axis_tready=0; m_axis_tvalid/tlast/tuser=0; m_axis_tdata=0.
- IDLE:
  - When cfg_enable=1 and any s_axis_tvalid=1, choose the first requesting port searching upward from (last+1) mod S_COUNT, wrapping.
  - Register that index into grant_index and the last pointer; set grant_valid=1; go to ACTIVE.
  - Grant latency is 1 cycle after tvalid. No data transfers in the IDLE cycle.
- ACTIVE:
  - m_axis_tdata/tvalid/tlast/tuser are a combinational mux of the granted port.
  - s_axis_tready[grant_index]=m_axis_tready; all other treadys are 0. This gives zero added latency.
  - When the beat with tlast=1 is accepted (m_axis_tvalid & m_axis_tready & m_axis_tlast): grant_valid=0, go to IDLE. Always 1 idle bubble between frames; the MAC's IFG dominates anyway.
- Watchdog (TIMEOUT>0):
  - In ACTIVE, the counter increments each cycle the granted tvalid=0 and clears on any granted tvalid=1.
  - When the counter reaches TIMEOUT-1 with tvalid still 0: pulse abort_event and go to ABORT.
  - Back-pressure (tvalid=1, tready=0) never counts.
- ABORT:
  - Drive m_axis_tvalid=1, tdata=8'h00, tlast=1, tuser=1; all s_axis_tready=0.
  - Hold until m_axis_tready=1, then go to DRAIN.
- DRAIN:
  - s_axis_tready[grant_index]=1 and m_axis_tvalid=0; discard source beats until its tlast beat is accepted.
  - Then grant_valid=0, go to IDLE.
- cfg_enable:
  - Sampled only in IDLE; deassertion mid-frame has no effect until the frame ends.
- Simultaneous events:
  - If tlast is accepted in the same cycle the timeout would fire, tlast wins and there is no abort.
  - If all ports request, strict rotation gives each port exactly 1 frame per S_COUNT grants.
- Reset mid-frame:
  - Everything returns to reset values the next cycle; the partial frame is abandoned without a tlast.
  - The MAC's own underflow handling covers the abandoned frame.
- Width rules:
  - The stall counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.

Optional Feature:
- Macro ETH_MAC_TX_ARB_STATS_EN.
- When defined:
  - Adds output stat_frame_count (S_COUNT*16) and stat_abort_count (16).
  - Per-port 16-bit counters increment on each accepted tlast beat from that port; stat_abort_count increments on abort_event.
  - All counters wrap at 16'hFFFF→0 and reset to 0.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package eth_pkg, which holds:
  - typedef tx_arb_state_t {IDLE, ACTIVE, ABORT, DRAIN} (2-bit enum).
  - Constant ETH_ABORT_BYTE=8'h00.
- One natural sub-module: rr_arb_sel.
  - Combinational round-robin picker with inputs request[S_COUNT] and last[CL_S_COUNT].
  - Outputs index and found.
  - Reusable by other arbiters in the codebase.

Test Plan:
- Ports 0 and 2 each offer one 64-byte frame at once, m_axis_tready=1 → port 0 frame fully out, 1 bubble cycle, then port 2 frame; grant_index 0 then 2.
- All 4 ports continuously valid, 8 frames of 10 bytes → grant order 0,1,2,3,0,1,2,3; no byte interleaving; tlast count = 8.
- Port 1 granted, sends 5 bytes then tvalid=0 for 64 cycles (TIMEOUT=64) → abort_event pulses once; MAC sees 6th beat 8'h00 with tlast=1, tuser=1; remaining port-1 bytes are drained with m_axis_tvalid=0 until their tlast.
- m_axis_tready=0 for 200 cycles mid-frame with the source valid → no abort; data resumes intact when tready rises.
- cfg_enable dropped mid-frame on port 3 → frame completes, no new grant while cfg_enable=0; re-enable → grant 1 cycle later to port 0.
- rst asserted mid-frame → next cycle all tready=0, grant_valid=0, m_axis_tvalid=0; first post-reset grant goes to port 0. With ETH_MAC_TX_ARB_STATS_EN, all counters read 0.
